// File: rtl/scrf_prog_if.sv
// Host-side bus of the programmable system config register file:
// shadow write port, shadow read-back port and commit handshake.
interface scrf_prog_if #(
    parameter int ADDR_W = 6
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_err;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              commit_req;
    logic              datapath_idle;
    logic              commit_done;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_addr, commit_req, datapath_idle,
        output wr_ready, wr_err, rd_data, commit_done
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_addr, commit_req, datapath_idle,
        input  wr_ready, wr_err, rd_data, commit_done
    );
endinterface

// File: rtl/scrf_prog.sv
// Programmable system config register file. The host fills a shadow copy word
// by word; a commit copies the whole shadow into the active config outputs in
// one cycle, but only once the datapath reports idle.
//
//  state | meaning
//  IDLE  | shadow matches active config
//  DIRTY | shadow written since the last commit
//  PEND  | commit requested, waiting for datapath_idle; host writes stalled
module scrf_prog #(
    parameter int NUM_IPORT = 12,
    parameter int NUM_OPORT = 2,
    parameter int ADDR_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    scrf_prog_if.slave                bus,
    output logic                      cfg_valid,
    output logic [22:0]               dfsm_config,
    output logic [19:0]               ssp_config,
    output logic [37:0]               quabuf_config,
    output logic [25:0]               singbuf_config,
    output logic                      mode_conv_mm,
    output logic                      mode_conv_isac,
    output logic                      mode_conv_isrelu,
    output logic                      mode_conv_isbn,
    output logic [5:0]                pe_config,
    output logic [56*NUM_IPORT-1:0]   iport_config,
    output logic [56*NUM_OPORT-1:0]   oport_config
);
    localparam int NWORDS = 6 + 2 * (NUM_IPORT + NUM_OPORT);
    localparam logic [ADDR_W:0] NWORDS_A = (ADDR_W + 1)'(NWORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIRTY = 2'd1,
        PEND  = 2'd2
    } state_t;

    // Bits of each word that are actually backed by storage; the rest read as 0.
    // Port fields are 56 bits: the even word carries [31:0], the odd word [55:32].
    function automatic logic [31:0] word_mask(input int w);
        logic [31:0] m;
        case (w)
            0:       m = 32'h007F_FFFF;
            1:       m = 32'h000F_FFFF;
            2:       m = 32'hFFFF_FFFF;
            3:       m = 32'h0000_003F;
            4:       m = 32'h03FF_FFFF;
            5:       m = 32'h0000_03FF;
            default: m = (((w - 6) % 2) == 0) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
        endcase
        return m;
    endfunction

    state_t      state_q, state_d;
    logic        ready;
    logic        commit_fire;
    logic        wr_fire;
    logic        wr_in_range;
    logic        rd_in_range;
    logic [31:0] wr_mask;
    logic [31:0] shadow [NWORDS];

    logic [56*NUM_IPORT-1:0] iport_shadow;
    logic [56*NUM_OPORT-1:0] oport_shadow;

    assign wr_in_range  = {1'b0, bus.wr_addr} < NWORDS_A;
    assign rd_in_range  = {1'b0, bus.rd_addr} < NWORDS_A;
    assign wr_fire      = bus.wr_valid & ready;
    assign bus.wr_ready = ready;

    // Field mask for the word currently being written.
    always_comb begin
        wr_mask = word_mask(int'(bus.wr_addr));
    end

    // Commit FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Commit FSM next state; commit_req wins over a same-cycle write because
    // that write already lands in shadow before the copy happens.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b1;
        commit_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.commit_req)                 state_d = PEND;
                else if (wr_fire && wr_in_range)    state_d = DIRTY;
            end
            DIRTY: begin
                if (bus.commit_req)                 state_d = PEND;
            end
            PEND: begin
                ready = 1'b0;
                if (bus.datapath_idle) begin
                    commit_fire = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow register file; only field-width bits are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '{default: '0};
        end else if (wr_fire && wr_in_range) begin
            shadow[bus.wr_addr] <= bus.wr_data & wr_mask;
        end
    end

    // Out-of-range writes are accepted and dropped, flagged one cycle later.
    always_ff @(posedge clk) begin
        if (rst) bus.wr_err <= 1'b0;
        else     bus.wr_err <= wr_fire & ~wr_in_range;
    end

    // Registered read-back, forwarding a write accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || !rd_in_range) begin
            bus.rd_data <= '0;
        end else if (wr_fire && wr_in_range && (bus.wr_addr == bus.rd_addr)) begin
            bus.rd_data <= bus.wr_data & wr_mask;
        end else begin
            bus.rd_data <= shadow[bus.rd_addr];
        end
    end

    // Flatten shadow port words into the active port-field layout.
    for (genvar i = 0; i < NUM_IPORT; i++) begin : g_iport
        assign iport_shadow[56*i +: 56] = {shadow[7 + 2*i][23:0], shadow[6 + 2*i]};
    end
    for (genvar j = 0; j < NUM_OPORT; j++) begin : g_oport
        assign oport_shadow[56*j +: 56] =
            {shadow[7 + 2*(NUM_IPORT + j)][23:0], shadow[6 + 2*(NUM_IPORT + j)]};
    end

    // Active config: changes only on the commit cycle (or reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.commit_done  <= 1'b0;
            cfg_valid        <= 1'b0;
            dfsm_config      <= '0;
            ssp_config       <= '0;
            quabuf_config    <= '0;
            singbuf_config   <= '0;
            mode_conv_mm     <= 1'b0;
            mode_conv_isac   <= 1'b0;
            mode_conv_isrelu <= 1'b0;
            mode_conv_isbn   <= 1'b0;
            pe_config        <= '0;
            iport_config     <= '0;
            oport_config     <= '0;
        end else begin
            bus.commit_done <= commit_fire;
            if (commit_fire) begin
                cfg_valid        <= 1'b1;
                dfsm_config      <= shadow[0][22:0];
                ssp_config       <= shadow[1][19:0];
                quabuf_config    <= {shadow[3][5:0], shadow[2]};
                singbuf_config   <= shadow[4][25:0];
                mode_conv_mm     <= shadow[5][0];
                mode_conv_isac   <= shadow[5][1];
                mode_conv_isrelu <= shadow[5][2];
                mode_conv_isbn   <= shadow[5][3];
                pe_config        <= shadow[5][9:4];
                iport_config     <= iport_shadow;
                oport_config     <= oport_shadow;
            end
        end
    end
endmodule

// File: tb/tb_scrf_prog.sv
// Directed bench for scrf_prog: shadow writes/read-back, commit handshake,
// out-of-range writes and reset during a pending commit.
module tb_scrf_prog;
    localparam int NI     = 12;
    localparam int NO     = 2;
    localparam int AW     = 6;
    localparam int NWORDS = 6 + 2 * (NI + NO);

    typedef logic [767:0] cw_t;
    typedef struct packed {
        logic [22:0]      dfsm;
        logic [19:0]      ssp;
        logic [37:0]      quabuf;
        logic [25:0]      singbuf;
        logic [9:0]       w5;
        logic [56*NI-1:0] ip;
        logic [56*NO-1:0] op;
    } cfg_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scrf_prog_if #(.ADDR_W(AW)) bus ();

    logic             cfg_valid;
    logic [22:0]      dfsm_config;
    logic [19:0]      ssp_config;
    logic [37:0]      quabuf_config;
    logic [25:0]      singbuf_config;
    logic             mode_conv_mm, mode_conv_isac, mode_conv_isrelu, mode_conv_isbn;
    logic [5:0]       pe_config;
    logic [56*NI-1:0] iport_config;
    logic [56*NO-1:0] oport_config;

    scrf_prog #(.NUM_IPORT(NI), .NUM_OPORT(NO), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .cfg_valid        (cfg_valid),
        .dfsm_config      (dfsm_config),
        .ssp_config       (ssp_config),
        .quabuf_config    (quabuf_config),
        .singbuf_config   (singbuf_config),
        .mode_conv_mm     (mode_conv_mm),
        .mode_conv_isac   (mode_conv_isac),
        .mode_conv_isrelu (mode_conv_isrelu),
        .mode_conv_isbn   (mode_conv_isbn),
        .pe_config        (pe_config),
        .iport_config     (iport_config),
        .oport_config     (oport_config)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] sh_m [NWORDS];
    cfg_t        act_m;
    logic        cfg_valid_m;
    cfg_t        commit_q [$];
    logic [31:0] rd_q [$];

    // Field widths of each word as laid out in the config map.
    function automatic logic [31:0] fmask(input int w);
        case (w)
            0: return (32'd1 << 23) - 32'd1;
            1: return (32'd1 << 20) - 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return (32'd1 << 6) - 32'd1;
            4: return (32'd1 << 26) - 32'd1;
            5: return (32'd1 << 10) - 32'd1;
            default: return (w % 2 == 0) ? 32'hFFFF_FFFF : (32'd1 << 24) - 32'd1;
        endcase
    endfunction

    function automatic cfg_t model_cfg();
        cfg_t c;
        c.dfsm    = sh_m[0][22:0];
        c.ssp     = sh_m[1][19:0];
        c.quabuf  = {sh_m[3][5:0], sh_m[2]};
        c.singbuf = sh_m[4][25:0];
        c.w5      = sh_m[5][9:0];
        for (int i = 0; i < NI; i++)
            c.ip[56*i +: 56] = {sh_m[7 + 2*i][23:0], sh_m[6 + 2*i]};
        for (int j = 0; j < NO; j++)
            c.op[56*j +: 56] = {sh_m[7 + 2*(NI + j)][23:0], sh_m[6 + 2*(NI + j)]};
        return c;
    endfunction

    task automatic chk(input string tag, input cw_t obs, input cw_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; retire a commit from the scoreboard when commit_done shows,
    // then check every active output against the expected active image.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.commit_done === 1'b1) begin
            if (commit_q.size() == 0) begin
                chk("spurious_done", cw_t'(bus.commit_done), cw_t'(0));
            end else begin
                act_m       = commit_q.pop_front();
                cfg_valid_m = 1'b1;
            end
        end
        chk("cfg_valid", cw_t'(cfg_valid), cw_t'(cfg_valid_m));
        chk("dfsm",      cw_t'(dfsm_config), cw_t'(act_m.dfsm));
        chk("ssp",       cw_t'(ssp_config), cw_t'(act_m.ssp));
        chk("quabuf",    cw_t'(quabuf_config), cw_t'(act_m.quabuf));
        chk("singbuf",   cw_t'(singbuf_config), cw_t'(act_m.singbuf));
        chk("word5",     cw_t'({pe_config, mode_conv_isbn, mode_conv_isrelu,
                                mode_conv_isac, mode_conv_mm}), cw_t'(act_m.w5));
        chk("iport",     cw_t'(iport_config), cw_t'(act_m.ip));
        chk("oport",     cw_t'(oport_config), cw_t'(act_m.op));
    endtask

    task automatic rd(input int a);
        bus.rd_addr = AW'(a);
        rd_q.push_back((a < NWORDS) ? sh_m[a] : 32'h0);
        tick();
        chk("rd_data", cw_t'(bus.rd_data), cw_t'(rd_q.pop_front()));
    endtask

    // Write with read-back of the same address in the same cycle.
    task automatic wr(input int a, input logic [31:0] d);
        chk("wr_ready", cw_t'(bus.wr_ready), cw_t'(1));
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(a);
        bus.wr_data  = d;
        bus.rd_addr  = AW'(a);
        if (a < NWORDS) sh_m[a] = d & fmask(a);
        rd_q.push_back((a < NWORDS) ? sh_m[a] : 32'h0);
        tick();
        bus.wr_valid = 1'b0;
        chk("wr_err", cw_t'(bus.wr_err), cw_t'(a >= NWORDS));
        chk("rd_fwd", cw_t'(bus.rd_data), cw_t'(rd_q.pop_front()));
    endtask

    // commit_req for one cycle, optionally with a write in the same cycle;
    // datapath_idle held low for idle_wait cycles of PEND.
    task automatic commit(input int idle_wait, input logic with_wr,
                          input int a, input logic [31:0] d);
        if (with_wr) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(a);
            bus.wr_data  = d;
            sh_m[a]      = d & fmask(a);
        end
        bus.commit_req    = 1'b1;
        bus.datapath_idle = (idle_wait == 0);
        commit_q.push_back(model_cfg());
        tick();
        bus.wr_valid   = 1'b0;
        bus.commit_req = 1'b0;
        chk("early_done", cw_t'(bus.commit_done), cw_t'(0));
        chk("pend_ready", cw_t'(bus.wr_ready), cw_t'(0));
        for (int i = 0; i < idle_wait; i++) begin
            bus.commit_req = (i == 3);
            tick();
            chk("stall_ready", cw_t'(bus.wr_ready), cw_t'(0));
            chk("stall_done", cw_t'(bus.commit_done), cw_t'(0));
        end
        bus.commit_req    = 1'b0;
        bus.datapath_idle = 1'b1;
        tick();
        chk("commit_done", cw_t'(bus.commit_done), cw_t'(1));
        chk("ready_back", cw_t'(bus.wr_ready), cw_t'(1));
        bus.datapath_idle = 1'b0;
        tick();
        chk("done_pulse", cw_t'(bus.commit_done), cw_t'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.wr_valid      = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.rd_addr       = '0;
        bus.commit_req    = 1'b0;
        bus.datapath_idle = 1'b0;
        foreach (sh_m[k]) sh_m[k] = '0;
        act_m       = '0;
        cfg_valid_m = 1'b0;

        // Reset state and read-back of every word, plus one past the end.
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", cw_t'(bus.wr_ready), cw_t'(1));
        chk("rst_err", cw_t'(bus.wr_err), cw_t'(0));
        for (int a = 0; a <= NWORDS; a++) rd(a);

        // Single DFSM word commit with datapath already idle.
        wr(0, 32'h0008_0063);
        commit(0, 1'b0, 0, 32'h0);
        chk("dfsm_val", cw_t'(dfsm_config), cw_t'(23'd524387));

        // Quad-buffer field spans two words; word3 keeps only 6 bits.
        wr(2, 32'h21);
        wr(3, 32'h30);
        commit(0, 1'b0, 0, 32'h0);
        chk("quabuf_val", cw_t'(quabuf_config), cw_t'(38'h30_0000_0021));
        wr(3, 32'h0000_FFFF);
        rd(3);
        chk("word3_rb", cw_t'(bus.rd_data), cw_t'(32'h3F));

        // Commit held off by a busy datapath for 10 cycles.
        wr(1, 32'hFFAB_CDEF);
        wr(5, 32'hFFFF_FC5A);
        wr(4, 32'hA5A5_A5A5);
        wr(33, 32'hFF12_3456);
        wr(20, 32'h0BAD_F00D);
        commit(10, 1'b0, 0, 32'h0);
        chk("ssp_val", cw_t'(ssp_config), cw_t'(20'hBCDEF));
        chk("pe_val", cw_t'(pe_config), cw_t'(6'h05));
        chk("isac_val", cw_t'(mode_conv_isac), cw_t'(1));
        chk("isbn_val", cw_t'(mode_conv_isbn), cw_t'(1));

        // Out-of-range write is dropped with a one-cycle error pulse.
        wr(NWORDS, 32'hDEAD_BEEF);
        tick();
        chk("err_pulse", cw_t'(bus.wr_err), cw_t'(0));
        for (int a = 0; a < NWORDS; a++) rd(a);

        // Write and commit_req in the same cycle: write is part of the commit.
        commit(0, 1'b1, 6, 32'hCAFE_F00D);

        // Reset while a commit is pending.
        bus.wr_valid      = 1'b1;
        bus.wr_addr       = AW'(7);
        bus.wr_data       = 32'h1234_5678;
        bus.commit_req    = 1'b1;
        bus.datapath_idle = 1'b0;
        tick();
        bus.wr_valid   = 1'b0;
        bus.commit_req = 1'b0;
        tick();
        chk("pend2_ready", cw_t'(bus.wr_ready), cw_t'(0));
        rst = 1'b1;
        foreach (sh_m[k]) sh_m[k] = '0;
        act_m       = '0;
        cfg_valid_m = 1'b0;
        tick();
        rst               = 1'b0;
        bus.datapath_idle = 1'b1;
        tick();
        tick();
        chk("rst2_ready", cw_t'(bus.wr_ready), cw_t'(1));
        rd(6);
        rd(7);
        bus.datapath_idle = 1'b0;
        commit(2, 1'b0, 0, 32'h0);
        chk("q_drained", cw_t'(commit_q.size()), cw_t'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
